// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two
// requesters, holds operands for a settle window and registers the response.
module alu_share_arbiter #(
  parameter int         XLEN        = 32,
  parameter int         EXEC_CYCLES = 1,
  parameter logic [2:0] IDLE_CTRL   = 3'b011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [2:0]      req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [2:0]      req1_ctrl,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_sign,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic            resp_sign,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic [3:0]      cnt;
  logic [XLEN-1:0] op_src1;
  logic [XLEN-1:0] op_src2;
  logic [2:0]      op_ctrl;
  logic            op_id;
  logic            grant0;
  logic            grant1;
  logic            hs;
  logic            done;

  // Tie goes to the port that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b01: grant0 = 1'b1;
      2'b10: grant1 = 1'b1;
      2'b11: begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end
      default: ;
    endcase
  end

  assign hs   = req0_ready | req1_ready;
  assign done = (state == EXEC) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (done) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    alu_src1   = op_src1;
    alu_src2   = op_src2;
    alu_ctrl   = (state == EXEC) ? op_ctrl : IDLE_CTRL;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      cnt         <= 4'd0;
      op_src1     <= '0;
      op_src2     <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_sign   <= 1'b0;
    end else begin
      if (hs) begin
        op_src1    <= req1_ready ? req1_src1 : req0_src1;
        op_src2    <= req1_ready ? req1_src2 : req0_src2;
        op_ctrl    <= req1_ready ? req1_ctrl : req0_ctrl;
        op_id      <= req1_ready;
        last_grant <= req1_ready;
        cnt        <= CNT_INIT;
      end
      if ((state == EXEC) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      if (done) begin
        resp_valid  <= 1'b1;
        resp_id     <= op_id;
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_sign   <= alu_sign;
      end
      if ((state == RESP) && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU
// behind each instance (EXEC_CYCLES=1 and EXEC_CYCLES=3).
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_src1 = 0, req0_src2 = 0, req1_src1 = 0, req1_src2 = 0;
  logic [2:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic [31:0] alu_src1, alu_src2, alu_result, resp_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_sign;
  logic        resp_valid, resp_id, resp_zero, resp_sign, busy;
  logic        resp_ready = 0;

  logic        b_req0_valid = 0, b_req1_valid = 0;
  logic        b_req0_ready, b_req1_ready;
  logic [31:0] b_req0_src1 = 0, b_req0_src2 = 0, b_req1_src1 = 0, b_req1_src2 = 0;
  logic [2:0]  b_req0_ctrl = 0, b_req1_ctrl = 0;
  logic [31:0] b_alu_src1, b_alu_src2, b_alu_result, b_resp_result;
  logic [2:0]  b_alu_ctrl;
  logic        b_alu_zero, b_alu_sign;
  logic        b_resp_valid, b_resp_id, b_resp_zero, b_resp_sign, b_busy;
  logic        b_resp_ready = 1;

  function automatic logic [31:0] alu_f(logic [2:0] c, logic [31:0] a,
                                        logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return a - b;
      3'b101:  return a >> b[4:0];
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_ctrl, alu_src1, alu_src2);
  assign alu_zero     = (alu_result == 32'd0);
  assign alu_sign     = alu_result[31];
  assign b_alu_result = alu_f(b_alu_ctrl, b_alu_src1, b_alu_src2);
  assign b_alu_zero   = (b_alu_result == 32'd0);
  assign b_alu_sign   = b_alu_result[31];

  alu_share_arbiter #(.XLEN(32), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ctrl(req1_ctrl),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_sign(resp_sign), .busy(busy)
  );

  alu_share_arbiter #(.XLEN(32), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req0_src1(b_req0_src1), .req0_src2(b_req0_src2), .req0_ctrl(b_req0_ctrl),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .req1_src1(b_req1_src1), .req1_src2(b_req1_src2), .req1_ctrl(b_req1_ctrl),
    .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_ctrl(b_alu_ctrl),
    .alu_result(b_alu_result), .alu_zero(b_alu_zero), .alu_sign(b_alu_sign),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
    .resp_result(b_resp_result), .resp_zero(b_resp_zero),
    .resp_sign(b_resp_sign), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait for resp_valid, checking ready exclusivity every cycle.
  task automatic wait_resp(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_excl"}, 32'(req0_ready & req1_ready), 0);
      if (resp_valid) seen = 1;
    end
    chk({tag, "_to"}, 32'(seen), 1);
  endtask

  initial begin
    // reset state
    cyc(); cyc(); #1;
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'(alu_ctrl), 3);
    chk("rst_src1", alu_src1, 0);
    chk("rst_res", resp_result, 0);
    chk("rst_id", 32'(resp_id), 0);
    chk("rst_b_valid", 32'(b_resp_valid), 0);

    // 1: single op
    rst = 0;
    req0_valid = 1; req0_src1 = 5; req0_src2 = 7; req0_ctrl = 3'b000;
    resp_ready = 1;
    #1;
    chk("t1_r0", 32'(req0_ready), 1);
    chk("t1_r1", 32'(req1_ready), 0);
    cyc(); req0_valid = 0; #1;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ctrl", 32'(alu_ctrl), 0);
    chk("t1_src1", alu_src1, 5);
    chk("t1_nv", 32'(resp_valid), 0);
    cyc(); #1;
    chk("t1_valid", 32'(resp_valid), 1);
    chk("t1_res", resp_result, 12);
    chk("t1_zero", 32'(resp_zero), 0);
    chk("t1_id", 32'(resp_id), 0);
    cyc(); #1;
    chk("t1_idle", 32'(busy), 0);
    chk("t1_drop", 32'(resp_valid), 0);
    chk("t1_keep", resp_result, 12);

    // 2: tie arbitration from fresh reset
    rst = 1; cyc(); rst = 0;
    req0_valid = 1; req0_ctrl = 3'b010; req0_src1 = 9; req0_src2 = 9;
    req1_valid = 1; req1_ctrl = 3'b110; req1_src1 = 32'hF0; req1_src2 = 32'h0F;
    for (int k = 0; k < 4; k++) begin
      wait_resp("t2");
      chk("t2_id", 32'(resp_id), 32'(k % 2));
      chk("t2_res", resp_result, (k % 2) ? 32'hFF : 32'h0);
      chk("t2_zero", 32'(resp_zero), (k % 2) ? 0 : 1);
    end
    req0_valid = 0; req1_valid = 0;

    // 3: backpressure
    cyc();
    req0_valid = 1; req0_ctrl = 3'b000; req0_src1 = 20; req0_src2 = 22;
    req1_valid = 1; req1_ctrl = 3'b110; req1_src1 = 32'hF0; req1_src2 = 32'h0F;
    resp_ready = 0;
    #1;
    chk("t3_r0", 32'(req0_ready), 1);
    cyc(); req0_valid = 0;
    wait_resp("t3");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); #1; end
      chk("t3_valid", 32'(resp_valid), 1);
      chk("t3_res", resp_result, 42);
      chk("t3_id", 32'(resp_id), 0);
      chk("t3_rdy", 32'(req0_ready | req1_ready), 0);
    end
    cyc(); resp_ready = 1; #1;
    chk("t3_hold", 32'(resp_valid), 1);
    cyc(); #1;
    chk("t3_idle", 32'(busy), 0);
    chk("t3_drop", 32'(resp_valid), 0);
    chk("t3_keep", resp_result, 42);
    chk("t3_r1", 32'(req1_ready), 1);
    cyc(); req1_valid = 0;
    wait_resp("t3b");
    chk("t3b_id", 32'(resp_id), 1);
    chk("t3b_res", resp_result, 32'hFF);

    // 4: back-to-back identical opcode
    cyc();
    req1_valid = 1; req1_ctrl = 3'b000; req1_src1 = 1; req1_src2 = 1;
    #1;
    chk("t4_r1", 32'(req1_ready), 1);
    chk("t4_ic0", 32'(alu_ctrl), 3);
    cyc(); req1_src1 = 2; req1_src2 = 3; #1;
    chk("t4_ctrl_a", 32'(alu_ctrl), 0);
    chk("t4_src_a", {alu_src1[15:0], alu_src2[15:0]}, 32'h0001_0001);
    chk("t4_nr", 32'(req1_ready), 0);
    cyc(); #1;
    chk("t4_res_a", resp_result, 2);
    chk("t4_ic1", 32'(alu_ctrl), 3);
    cyc(); #1;
    chk("t4_ic2", 32'(alu_ctrl), 3);
    chk("t4_r1b", 32'(req1_ready), 1);
    cyc(); req1_valid = 0; #1;
    chk("t4_ctrl_b", 32'(alu_ctrl), 0);
    chk("t4_src_b", alu_src1, 2);
    cyc(); #1;
    chk("t4_res_b", resp_result, 5);
    chk("t4_id", 32'(resp_id), 1);

    // 5: EXEC_CYCLES=3 instance
    cyc();
    b_req0_valid = 1; b_req0_ctrl = 3'b101;
    b_req0_src1 = 32'h8000_0000; b_req0_src2 = 4;
    #1;
    chk("t5_r0", 32'(b_req0_ready), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); b_req0_valid = 0; #1;
      chk("t5_ctrl", 32'(b_alu_ctrl), 32'h5);
      chk("t5_src1", b_alu_src1, 32'h8000_0000);
      chk("t5_src2", b_alu_src2, 4);
      chk("t5_nv", 32'(b_resp_valid), 0);
    end
    cyc(); #1;
    chk("t5_valid", 32'(b_resp_valid), 1);
    chk("t5_res", b_resp_result, 32'h0800_0000);
    chk("t5_sign", 32'(b_resp_sign), 0);

    // 6a: reset during EXEC
    cyc();
    req0_valid = 1; req0_ctrl = 3'b000; req0_src1 = 7; req0_src2 = 8;
    resp_ready = 1;
    #1;
    chk("t6_r0", 32'(req0_ready), 1);
    cyc(); req0_valid = 0; rst = 1; #1;
    chk("t6_exec", 32'(busy), 1);
    cyc(); rst = 0; #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(resp_valid), 0);
    chk("t6_ctrl", 32'(alu_ctrl), 3);
    chk("t6_src1", alu_src1, 0);
    chk("t6_res", resp_result, 0);
    chk("t6_id", 32'(resp_id), 0);
    req0_valid = 1; req1_valid = 1; #1;
    chk("t6_tie0", 32'(req0_ready), 1);
    chk("t6_tie1", 32'(req1_ready), 0);
    req0_valid = 0; req1_valid = 0;
    cyc(); #1;
    chk("t6_noresp", 32'(resp_valid), 0);
    chk("t6_idle", 32'(busy), 0);

    // 6b: reset during RESP
    cyc();
    req1_valid = 1; req1_ctrl = 3'b110; req1_src1 = 32'h30; req1_src2 = 32'h03;
    resp_ready = 0;
    #1;
    chk("t6b_r1", 32'(req1_ready), 1);
    cyc(); req1_valid = 0;
    cyc(); #1;
    chk("t6b_valid", 32'(resp_valid), 1);
    chk("t6b_id", 32'(resp_id), 1);
    chk("t6b_res", resp_result, 32'h33);
    rst = 1;
    cyc(); rst = 0; #1;
    chk("t6b_rvalid", 32'(resp_valid), 0);
    chk("t6b_rid", 32'(resp_id), 0);
    chk("t6b_rres", resp_result, 0);
    chk("t6b_busy", 32'(busy), 0);
    cyc(); #1;
    chk("t6b_noresp", 32'(resp_valid), 0);
    req0_valid = 1; req1_valid = 1; resp_ready = 1; #1;
    chk("t6b_tie0", 32'(req0_ready), 1);
    chk("t6b_tie1", 32'(req1_ready), 0);
    req0_valid = 0; req1_valid = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Sequences and shares the single combinational integer ALU between two requesters, e.g. the execute datapath (port 0) and the branch/compare unit (port 1).
- Accepts one operation at a time over valid/ready handshakes, with round-robin arbitration.
- Drives the ALU operand and control inputs, holds them for a programmable settle window, then captures result and flags into a response register.
- Holds the response until the consumer accepts it.

Parameters:
- XLEN, 32, operand/result width.
- EXEC_CYCLES, 1, cycles operands are held on the ALU before capture (1..15).
- IDLE_CTRL, 3'b011, ALU control code driven outside EXEC (unused opcode, result 0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_src1, req0_src2  in  XLEN  requester 0 operands.
- req0_ctrl  in  3  requester 0 ALU control code.
- req1_valid, req1_ready, req1_src1, req1_src2, req1_ctrl: same as requester 0, for requester 1.
- alu_src1, alu_src2  out  XLEN  to ALU operands.
- alu_ctrl  out  3  to ALU control.
- alu_result  in  XLEN  from ALU.
- alu_zero, alu_sign  in  1  ALU flags.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester that issued the operation.
- resp_result  out  XLEN  captured result.
- resp_zero, resp_sign  out  1  captured flags, passed through unmodified.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (any state, any cycle):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), exec counter=0.
  - Latched operands=0, alu_ctrl=IDLE_CTRL.
  - resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_sign=0, busy=0.
  - An in-flight operation is discarded; no response is produced for it.
- Grant (combinational, IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the port != last_grant.
  - reqN_ready = (state==IDLE) & grantN; never both high.
  - Ready does not depend on resp_ready.
- IDLE -> EXEC on a handshake (reqN_valid & reqN_ready):
  - Latch srcs/ctrl/id.
  - last_grant <= N.
  - Load counter with EXEC_CYCLES-1.
- EXEC:
  - alu_src1/alu_src2/alu_ctrl are driven from the latches.
  - Counter decrements each cycle.
  - When the counter is 0: capture alu_result/alu_zero/alu_sign and id into the resp registers, set resp_valid, go to RESP.
- Outside EXEC: alu_ctrl = IDLE_CTRL and alu_src1/alu_src2 = latched values.
  - Every operation therefore presents a control-code change to the ALU, including back-to-back identical opcodes.
- RESP:
  - resp_* held stable while resp_valid & !resp_ready.
  - On resp_ready: resp_valid <= 0 next cycle, go to IDLE. resp_result/flags retain their last values.
- Latency: handshake in cycle N -> resp_valid high from cycle N+1+EXEC_CYCLES.
  - Minimum request-to-request spacing is EXEC_CYCLES+2 cycles.
- Requests are not queued; a requester holds valid and operands until ready.
  - Operand changes while not ready are permitted and ignored.
- resp_ready asserted while resp_valid=0 has no effect.
- Flag semantics are the ALU's own; the block does not reinterpret alu_sign polarity.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
1. Reset then single op: req0 src1=5, src2=7, ctrl=000, resp_ready=1.
   -> req0_ready in cycle 1; alu_ctrl=000 during EXEC; resp_valid 2 cycles after the handshake with resp_result=12, resp_zero=0, resp_id=0; busy deasserts after accept.
2. Tie arbitration: both valid continuously, req0 ctrl=010 src 9,9; req1 ctrl=110 src 0xF0,0x0F.
   -> order is port0 (result 0, zero=1), port1 (0xFF), port0, port1; req ready never both high.
3. Backpressure: resp_ready=0 for 5 cycles after resp_valid.
   -> resp_result/resp_id stable, req0_ready/req1_ready=0 throughout; accepted on the 6th cycle; IDLE the next cycle.
4. Back-to-back identical opcode: two req1 ops ctrl=000, (1,1) then (2,3).
   -> alu_ctrl shows 011 between the EXEC windows; results 2 then 5.
5. EXEC_CYCLES=3 build: req0 ctrl=101, src1=0x80000000, src2=4.
   -> operands held 3 cycles; resp_valid 4 cycles after the handshake; resp_result=0x08000000.
6. Reset mid-operation: assert rst during EXEC, and separately during RESP.
   -> next cycle all outputs at reset values and no response for the aborted op; after release, a tie grants port 0 first.
